// File: rtl/draw_pkg.sv
// draw_pkg: shared screen geometry, widths, FSM state type and colour key for the draw datapath.
package draw_pkg;
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int COLOUR_W     = 9;
    localparam int COORD_W      = 9;
    localparam logic [COLOUR_W-1:0] DEF_TRANSPARENT_COLOUR = 9'h1C7;
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;
endpackage

// File: rtl/draw_datapath_clear_sweeper.sv
// clear_sweeper: raster counter over the screen, x inner and y outer.
// start_i zeroes it, en_i advances it, last_o flags the bottom-right pixel.
module clear_sweeper
    import draw_pkg::*;
#(
    parameter int W = DEF_SCREEN_W,
    parameter int H = DEF_SCREEN_H
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_i,
    input  logic       en_i,
    output logic [8:0] x_o,
    output logic [7:0] y_o,
    output logic       last_o
);
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       x_end;

    always_comb begin
        x_end  = x_q == 9'(W - 1);
        last_o = x_end && y_q == 8'(H - 1);
        x_d    = start_i ? 9'd0 : en_i ? (x_end ? 9'd0 : x_q + 9'd1) : x_q;
        y_d    = start_i ? 8'd0 : (en_i && x_end) ? (last_o ? 8'd0 : y_q + 8'd1) : y_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/draw_datapath.sv
// draw_datapath: 2-stage clipped pixel plotter toward the VGA adapter plus a full-screen clear sweep.
// Define TRANSPARENT_EN to suppress pixels whose colour equals TRANSPARENT_COLOUR.
module draw_datapath
    import draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
`ifdef TRANSPARENT_EN
    ,
    parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = DEF_TRANSPARENT_COLOUR
`endif
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ld_pos,
    input  logic                ld_xy,
    input  logic                ld_colour,
    input  logic                draw_pixel,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [COORD_W-1:0]  dx,
    input  logic [COORD_W-1:0]  dy,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                clear_go,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic [8:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                clear_busy,
    output logic                clear_done
);
    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, dx_q, dx_d, dy_q, dy_d;
    logic [COLOUR_W-1:0] col_q, col_d, clr_col_q, clr_col_d;
    logic                s1_v_q, s1_v_d;
    logic [COORD_W:0]    sx_q, sx_d, sy_q, sy_d;
    logic [COLOUR_W-1:0] s1_col_q, s1_col_d;
    logic [8:0]          vga_x_q, vga_x_d;
    logic [7:0]          vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_col_q, vga_col_d;
    logic                vga_plot_q, vga_plot_d;
    logic                idle, sw_start, sw_en, sw_last, keep;
    logic [8:0]          sw_x;
    logic [7:0]          sw_y;

    clear_sweeper #(.W(SCREEN_W), .H(SCREEN_H)) u_sweep (
        .clock  (clock),
        .resetn (resetn),
        .start_i(sw_start),
        .en_i   (sw_en),
        .x_o    (sw_x),
        .y_o    (sw_y),
        .last_o (sw_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE  && clear_go) ? DRAIN :
                  (state_q == DRAIN && !s1_v_q)  ? CLEAR :
                  (state_q == CLEAR && sw_last)  ? DONE  :
                  (state_q == DONE)              ? IDLE  : state_q;
    end

    always_comb begin
        idle       = state_q == IDLE;
        sw_start   = state_q == DRAIN;
        sw_en      = state_q == CLEAR;
        clear_busy = sw_start || sw_en;
        clear_done = state_q == DONE;
    end

    // The *_d values double as the bypassed operands, so a load and a draw in one cycle use fresh data.
    always_comb begin
        x_d       = (idle && ld_pos)    ? x            : x_q;
        y_d       = (idle && ld_pos)    ? y            : y_q;
        dx_d      = (idle && ld_xy)     ? dx           : dx_q;
        dy_d      = (idle && ld_xy)     ? dy           : dy_q;
        col_d     = (idle && ld_colour) ? colour       : col_q;
        clr_col_d = (idle && clear_go)  ? clear_colour : clr_col_q;
        s1_v_d    = idle && draw_pixel;
        sx_d      = {1'b0, x_d} + {1'b0, dx_d};
        sy_d      = {1'b0, y_d} + {1'b0, dy_d};
        s1_col_d  = col_d;
    end

    always_comb begin
        keep = s1_v_q && sx_q < 10'(SCREEN_W) && sy_q < 10'(SCREEN_H)
`ifdef TRANSPARENT_EN
               && s1_col_q != TRANSPARENT_COLOUR
`endif
               ;
        vga_plot_d = sw_en || keep;
        vga_x_d    = sw_en ? sw_x      : keep ? sx_q[8:0] : vga_x_q;
        vga_y_d    = sw_en ? sw_y      : keep ? sy_q[7:0] : vga_y_q;
        vga_col_d  = sw_en ? clr_col_q : keep ? s1_col_q  : vga_col_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q        <= '0;
            y_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            col_q      <= '0;
            clr_col_q  <= '0;
            s1_v_q     <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            s1_col_q   <= '0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            vga_col_q  <= '0;
            vga_plot_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            col_q      <= col_d;
            clr_col_q  <= clr_col_d;
            s1_v_q     <= s1_v_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            s1_col_q   <= s1_col_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            vga_col_q  <= vga_col_d;
            vga_plot_q <= vga_plot_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_draw_datapath.sv
// tb_draw_datapath: directed checks of draw_datapath plotting, bypass, clipping, colour key, clear sweep and reset.
module tb_draw_datapath;
    logic       clock = 1'b0, resetn = 1'b0;
    logic       ld_pos, ld_xy, ld_colour, draw_pixel, clear_go;
    logic [8:0] x, y, dx, dy, colour, clear_colour;
    logic [8:0] vga_x, vga_colour;
    logic [7:0] vga_y;
    logic       vga_plot, clear_busy, clear_done;
    int         n_chk = 0, n_pass = 0;
`ifdef TRANSPARENT_EN
    localparam logic KEY_PLOTS = 1'b0;
`else
    localparam logic KEY_PLOTS = 1'b1;
`endif

    draw_datapath dut (
        .clock(clock), .resetn(resetn), .ld_pos(ld_pos), .ld_xy(ld_xy), .ld_colour(ld_colour),
        .draw_pixel(draw_pixel), .x(x), .y(y), .dx(dx), .dy(dy), .colour(colour),
        .clear_go(clear_go), .clear_colour(clear_colour), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        ld_pos = 0; ld_xy = 0; ld_colour = 0; draw_pixel = 0; clear_go = 0;
    endtask

    task automatic cmd(input logic lp, lx, lc, input logic [8:0] ix, iy, idx, idy, ic);
        ld_pos = lp; ld_xy = lx; ld_colour = lc; draw_pixel = 1;
        x = ix; y = iy; dx = idx; dy = idy; colour = ic;
    endtask

    task automatic draw(input logic lp, lx, lc, input logic [8:0] ix, iy, idx, idy, ic);
        cmd(lp, lx, lc, ix, iy, idx, idy, ic);
        tick();
        quiet();
        tick();
    endtask

    task automatic exp_plot(input string tag, input logic p, input logic [8:0] ex, input logic [7:0] ey,
                            input logic [8:0] ec);
        chk({tag, ".plot"}, vga_plot, p);
        if (p) begin
            chk({tag, ".x"}, vga_x, ex);
            chk({tag, ".y"}, vga_y, ey);
            chk({tag, ".col"}, vga_colour, ec);
        end
    endtask

    initial begin
        int np, nclr, ndone, errs, after, n;
        logic [8:0] cx, lx_;
        logic [7:0] cy, ly_;
        quiet();
        x = 0; y = 0; dx = 0; dy = 0; colour = 0; clear_colour = 0;
        repeat (3) tick();
        chk("rst.plot", vga_plot, 0);
        chk("rst.x", vga_x, 0);
        chk("rst.y", vga_y, 0);
        chk("rst.col", vga_colour, 0);
        chk("rst.busy", clear_busy, 0);
        chk("rst.done", clear_done, 0);
        resetn = 1;
        tick();

        cmd(1, 0, 1, 10, 20, 0, 0, 9'h038);
        tick();
        quiet();
        chk("lat.plot", vga_plot, 0);
        tick();
        exp_plot("draw0", 1, 10, 20, 9'h038);
        tick();
        chk("draw0.oneshot", vga_plot, 0);

        draw(1, 1, 0, 100, 50, 1, 1, 0);
        exp_plot("oldoff", 1, 101, 51, 9'h038);
        draw(0, 1, 0, 0, 0, 5, 7, 0);
        exp_plot("bypass", 1, 105, 57, 9'h038);
        draw(0, 0, 0, 0, 0, 0, 0, 0);
        exp_plot("held", 1, 105, 57, 9'h038);

        draw(1, 1, 0, 315, 0, 4, 0, 0);
        exp_plot("clip319", 1, 319, 0, 9'h038);
        draw(0, 1, 0, 0, 0, 5, 0, 0);
        chk("clip320.plot", vga_plot, 0);
        chk("clip320.xhold", vga_x, 319);
        draw(1, 1, 0, 0, 239, 0, 1, 0);
        chk("clip240.plot", vga_plot, 0);
        draw(0, 1, 0, 0, 0, 0, 0, 0);
        exp_plot("y239", 1, 0, 239, 9'h038);
        draw(1, 1, 0, 511, 0, 511, 0, 0);
        chk("nowrap.plot", vga_plot, 0);

        draw(1, 1, 1, 1, 1, 0, 0, 9'h1C7);
        chk("key1c7.plot", vga_plot, KEY_PLOTS);
        draw(0, 0, 1, 0, 0, 0, 0, 9'h1C6);
        exp_plot("key1c6", 1, 1, 1, 9'h1C6);

        cmd(1, 1, 1, 1, 2, 0, 0, 9'h0AA);
        tick();
        cmd(1, 1, 1, 3, 4, 0, 0, 9'h055);
        clear_go = 1; clear_colour = 9'h000;
        tick();
        quiet();
        chk("busy.rise", clear_busy, 1);
        np = 0; nclr = 0; ndone = 0; errs = 0; after = -1;
        cx = 0; cy = 0; lx_ = 0; ly_ = 0;
        for (int k = 0; k < 80000 && after != 0; k++) begin
            if (draw_pixel) quiet();
            if (vga_plot) begin
                if (np == 0) exp_plot("fly0", 1, 1, 2, 9'h0AA);
                else if (np == 1) exp_plot("fly1", 1, 3, 4, 9'h055);
                else begin
                    if (vga_x !== cx || vga_y !== cy || vga_colour !== 9'h000) errs++;
                    lx_ = vga_x; ly_ = vga_y;
                    nclr++;
                    if (cx == 319) begin cx = 0; cy++; end else cx++;
                    if (nclr == 500) cmd(1, 0, 1, 5, 5, 0, 0, 9'h1FF);
                end
                np++;
            end
            if (clear_done) begin
                ndone++;
                if (after < 0) begin
                    chk("busy.atdone", clear_busy, 0);
                    after = 5;
                end
            end
            if (after > 0) after--;
            tick();
        end
        chk("clr.count", nclr, 76800);
        chk("clr.order", errs, 0);
        chk("clr.last_x", lx_, 319);
        chk("clr.last_y", ly_, 239);
        chk("clr.done_cnt", ndone, 1);
        chk("busy.after", clear_busy, 0);
        draw(0, 0, 0, 0, 0, 0, 0, 0);
        exp_plot("regs_held", 1, 3, 4, 9'h055);

        clear_colour = 9'h1FF; clear_go = 1;
        tick();
        quiet();
        n = 0;
        for (int k = 0; k < 2000 && n < 1000; k++) begin
            tick();
            if (vga_plot) n++;
        end
        chk("rst.reach", n, 1000);
        #2 resetn = 0;
        #1;
        chk("arst.plot", vga_plot, 0);
        chk("arst.x", vga_x, 0);
        chk("arst.y", vga_y, 0);
        chk("arst.col", vga_colour, 0);
        chk("arst.busy", clear_busy, 0);
        repeat (3) @(posedge clock);
        #3 resetn = 1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (clear_done || vga_plot || clear_busy) n++;
        end
        chk("arst.quiet", n, 0);
        draw(1, 1, 1, 7, 8, 0, 0, 9'h1AB);
        exp_plot("post_rst", 1, 7, 8, 9'h1AB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
